// File: rtl/cpu_registers.sv
// cpu_registers: 64x32 int/float register file, 3 registered read ports with write-through, 1 write port, post-reset clear sequencer (o_busy)
module cpu_registers #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_busy,
  input  logic        i_stall,
  input  logic [5:0]  i_rs1_idx,
  input  logic [5:0]  i_rs2_idx,
  input  logic [5:0]  i_rs3_idx,
  output logic [31:0] o_rs1,
  output logic [31:0] o_rs2,
  output logic [31:0] o_rs3,
  input  logic        i_write_enable,
  input  logic [5:0]  i_write_idx,
  input  logic [31:0] i_write_data
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [5:0] count;
  logic [31:0] mem [64];
  logic [5:0] lat [3];
  logic [5:0] idx [3];
  logic [5:0] sel [3];
  logic [31:0] rd [3];
  logic wr;
  assign o_busy = state == CLEAR;
  assign wr = state == READY && i_write_enable && i_write_idx != 6'd0;
  assign idx[0] = i_rs1_idx;
  assign idx[1] = i_rs2_idx;
  assign idx[2] = i_rs3_idx;
  always_comb state_nxt = (state == CLEAR && (!CLEAR_ON_RESET || count == 6'd63)) ? READY : state;
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      sel[n] = i_stall ? lat[n] : idx[n];
      rd[n] = (state == CLEAR || sel[n] == 6'd0) ? 32'd0 :
              (wr && i_write_idx == sel[n]) ? i_write_data : mem[sel[n]];
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= CLEAR;
      count <= 6'd0;
      for (int n = 0; n < 3; n++) lat[n] <= 6'd0;
      o_rs1 <= 32'd0;
      o_rs2 <= 32'd0;
      o_rs3 <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) count <= count + 6'd1;
      for (int n = 0; n < 3; n++) lat[n] <= sel[n];
      o_rs1 <= rd[0];
      o_rs2 <= rd[1];
      o_rs3 <= rd[2];
    end
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      if (state == CLEAR && CLEAR_ON_RESET) mem[count] <= 32'd0;
      else if (wr) mem[i_write_idx] <= i_write_data;
    end
  end
endmodule

// File: tb/tb_cpu_registers.sv
// tb_cpu_registers: random + directed self-check of cpu_registers against a behavioural model
module tb_cpu_registers;
  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  logic o_busy;
  logic i_stall = 1'b0;
  logic [5:0] i_rs1_idx = '0, i_rs2_idx = '0, i_rs3_idx = '0;
  logic [31:0] o_rs1, o_rs2, o_rs3;
  logic i_write_enable = 1'b0;
  logic [5:0] i_write_idx = '0;
  logic [31:0] i_write_data = '0;
  int checks = 0;
  int failures = 0;
  logic [31:0] model [64];
  logic [5:0] lat [3];
  logic [31:0] exp_rs [3];
  int busy_left = 0;
  cpu_registers dut (
    .i_clock(i_clock), .i_reset(i_reset), .o_busy(o_busy), .i_stall(i_stall),
    .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx), .i_rs3_idx(i_rs3_idx),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rs3(o_rs3),
    .i_write_enable(i_write_enable), .i_write_idx(i_write_idx), .i_write_data(i_write_data)
  );
  always #5 i_clock = ~i_clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%08h want=%08h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic step();
    bit busy_now;
    @(posedge i_clock);
    if (i_reset) begin
      for (int i = 0; i < 64; i++) model[i] = 32'd0;
      busy_left = 64;
      for (int n = 0; n < 3; n++) begin lat[n] = 6'd0; exp_rs[n] = 32'd0; end
    end else begin
      busy_now = busy_left > 0;
      if (busy_now) busy_left--;
      else if (i_write_enable && i_write_idx != 6'd0) model[i_write_idx] = i_write_data;
      if (!i_stall) begin lat[0] = i_rs1_idx; lat[1] = i_rs2_idx; lat[2] = i_rs3_idx; end
      for (int n = 0; n < 3; n++) exp_rs[n] = (busy_now || lat[n] == 6'd0) ? 32'd0 : model[lat[n]];
    end
    #1;
    chk("busy", {31'd0, o_busy}, {31'd0, busy_left > 0});
    chk("rs1", o_rs1, exp_rs[0]);
    chk("rs2", o_rs2, exp_rs[1]);
    chk("rs3", o_rs3, exp_rs[2]);
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    i_write_enable = 1'b1; i_write_idx = a; i_write_data = d;
    step();
    i_write_enable = 1'b0;
  endtask
  task automatic rd3(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    i_rs1_idx = a; i_rs2_idx = b; i_rs3_idx = c;
    step();
  endtask
  task automatic reset_and_count(input int pre);
    int n;
    i_reset = 1'b1;
    step();
    chk("rst_rs1", o_rs1, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd1);
    i_reset = 1'b0;
    for (int i = 0; i < pre; i++) step();
    if (pre > 0) begin
      i_reset = 1'b1;
      step();
      chk("mid_rst_rs2", o_rs2, 32'd0);
      i_reset = 1'b0;
    end
    n = 0;
    while (o_busy && n < 100) begin
      i_write_enable = 1'b1; i_write_idx = 6'd3; i_write_data = 32'h5555_5555;
      step();
      n++;
    end
    i_write_enable = 1'b0;
    chk("clear_len", n, 32'd64);
  endtask
  initial begin
    i_reset = 1'b1;
    step();
    step();
    chk("reset_busy", {31'd0, o_busy}, 32'd1);
    chk("reset_rs3", o_rs3, 32'd0);
    reset_and_count(0);
    for (int i = 0; i < 64; i++) begin
      rd3(i[5:0], 6'(63 - i), i[5:0]);
      chk("cleared", o_rs1, 32'd0);
    end
    wr(6'd5, 32'hDEAD_BEEF);
    rd3(6'd5, 6'd0, 6'd37);
    chk("t5_rs1", o_rs1, 32'hDEAD_BEEF);
    chk("t5_rs2", o_rs2, 32'd0);
    chk("t5_rs3", o_rs3, 32'd0);
    i_rs1_idx = 6'd40; i_rs2_idx = 6'd40; i_rs3_idx = 6'd40;
    wr(6'd40, 32'h1234_5678);
    chk("wt_rs1", o_rs1, 32'h1234_5678);
    chk("wt_rs2", o_rs2, 32'h1234_5678);
    chk("wt_rs3", o_rs3, 32'h1234_5678);
    wr(6'd0, 32'hFFFF_FFFF);
    rd3(6'd0, 6'd0, 6'd0);
    chk("x0", o_rs1, 32'd0);
    wr(6'd32, 32'h3F80_0000);
    rd3(6'd32, 6'd32, 6'd0);
    chk("f0", o_rs1, 32'h3F80_0000);
    wr(6'd7, 32'h11);
    wr(6'd9, 32'h99);
    rd3(6'd0, 6'd7, 6'd0);
    chk("st_pre", o_rs2, 32'h11);
    i_stall = 1'b1;
    rd3(6'd0, 6'd9, 6'd0);
    chk("st_hold", o_rs2, 32'h11);
    wr(6'd7, 32'h22);
    chk("st_bypass", o_rs2, 32'h22);
    step();
    chk("st_track", o_rs2, 32'h22);
    i_stall = 1'b0;
    step();
    chk("st_release", o_rs2, 32'h99);
    reset_and_count(30);
    wr(6'd3, 32'hAA);
    rd3(6'd3, 6'd3, 6'd3);
    chk("t3_written", o_rs1, 32'hAA);
    reset_and_count(0);
    rd3(6'd3, 6'd3, 6'd3);
    chk("t3_cleared", o_rs3, 32'd0);
    for (int c = 0; c < 1500; c++) begin
      i_reset = ($urandom_range(0, 299) == 0);
      i_stall = ($urandom_range(0, 3) == 0);
      i_write_enable = ($urandom_range(0, 2) != 0);
      i_write_idx = 6'($urandom_range(0, 63));
      i_write_data = $urandom;
      i_rs1_idx = ($urandom_range(0, 3) == 0) ? i_write_idx : 6'($urandom_range(0, 63));
      i_rs2_idx = ($urandom_range(0, 3) == 0) ? i_write_idx : 6'($urandom_range(0, 63));
      i_rs3_idx = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      step();
    end
    i_reset = 1'b0;
    i_write_enable = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
